// File: rtl/perceptron_sched.sv
// perceptron_sched: round-robin sharing of one combinational perceptron classifier between two requesters.
// Optional per-requester result counters are enabled with `define PERCEPTRON_SCHED_STATS_EN.
module perceptron_sched #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [2:0] req0_edges,
    input  logic [3:0] req0_curves,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [2:0] req1_edges,
    input  logic [3:0] req1_curves,
    output logic       req1_ready,
    output logic [2:0] cls_edges,
    output logic [3:0] cls_curves,
    input  logic [3:0] cls_out,
    output logic       res_valid,
    output logic       res_id,
    output logic [3:0] res_class,
    input  logic       res_ready,
`ifdef PERCEPTRON_SCHED_STATS_EN
    output logic       busy,
    output logic [7:0] stat0_count,
    output logic [7:0] stat1_count
`else
    output logic       busy
`endif
);
    typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;
    state_t     state;
    logic       last_grant;
    logic       grant;
    logic [3:0] cnt;
    // on a tie the requester that did not win last time is served
    assign grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign req0_ready = state == IDLE && req0_valid && !grant;
    assign req1_ready = state == IDLE && req1_valid && grant;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
            cls_edges  <= '0;
            cls_curves <= '0;
            res_valid  <= 1'b0;
            res_id     <= 1'b0;
            res_class  <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req0_ready || req1_ready) begin
                    cls_edges  <= grant ? req1_edges : req0_edges;
                    cls_curves <= grant ? req1_curves : req0_curves;
                    res_id     <= grant;
                    last_grant <= grant;
                    cnt        <= 4'(SETTLE_CYCLES - 1);
                    busy       <= 1'b1;
                    state      <= DRIVE;
                end
                DRIVE: if (cnt == '0) begin
                    res_class <= cls_out;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                HOLD: if (res_ready) begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef PERCEPTRON_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat0_count <= '0;
            stat1_count <= '0;
        end else if (state == HOLD && res_ready) begin
            stat0_count <= (!res_id && stat0_count != 8'hff) ? stat0_count + 8'd1 : stat0_count;
            stat1_count <= (res_id && stat1_count != 8'hff) ? stat1_count + 8'd1 : stat1_count;
        end
    end
`endif
endmodule
